// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, fault causes and FSM states.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'b00,
    SIZE_HALF   = 2'b01,
    SIZE_WORD   = 2'b10,
    SIZE_DOUBLE = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    FAULT_SIZE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_BUS      = 2'b10,
    FAULT_TIMEOUT  = 2'b11
  } mem_fault_e;

  typedef enum logic [1:0] {
    MAU_IDLE      = 2'b00,
    MAU_REQ       = 2'b01,
    MAU_WAIT_DROP = 2'b10
  } mau_state_e;

  // Number of bytes touched by an access of the given size code.
  function automatic logic [3:0] size_bytes(input logic [1:0] op);
    return 4'd1 << op;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: places store data and strobes on the bus lanes and
// pulls load data back down to bit 0 with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OFFW = $clog2(XLEN / 8)
) (
  input  logic [1:0]      wr_op_i,
  input  logic [OFFW-1:0] wr_off_i,
  input  logic [XLEN-1:0] wr_data_i,
  output logic [NB-1:0]   wstrb_o,
  output logic [XLEN-1:0] wdata_o,
  input  logic [1:0]      rd_op_i,
  input  logic [OFFW-1:0] rd_off_i,
  input  logic            rd_unsigned_i,
  input  logic [XLEN-1:0] rd_data_i,
  output logic [XLEN-1:0] rd_ext_o
);

  logic [NB-1:0]   size_mask;
  logic [XLEN-1:0] lane_mask;
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] keep;
  logic            sign;

  // Lanes outside the strobe are forced to zero so the bus never sees stale data bits.
  always_comb begin
    size_mask = NB'((16'd1 << size_bytes(wr_op_i)) - 16'd1);
    wstrb_o   = size_mask << wr_off_i;
    for (int i = 0; i < NB; i++) begin
      lane_mask[8*i +: 8] = {8{wstrb_o[i]}};
    end
    wdata_o = (wr_data_i << {wr_off_i, 3'b000}) & lane_mask;
  end

  always_comb begin
    rd_shift = rd_data_i >> {rd_off_i, 3'b000};
    case (rd_op_i)
      SIZE_BYTE: begin keep = XLEN'(8'hFF);          sign = rd_shift[7];  end
      SIZE_HALF: begin keep = XLEN'(16'hFFFF);       sign = rd_shift[15]; end
      SIZE_WORD: begin keep = XLEN'(32'hFFFF_FFFF);  sign = rd_shift[31]; end
      default:   begin keep = '1;                    sign = 1'b0;         end
    endcase
    rd_ext_o = (rd_shift & keep) | ((sign & ~rd_unsigned_i) ? ~keep : '0);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: validates one sized access per request, runs it over a
// single-outstanding req/ack bus and reports completion or a fault cause.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                available_i,
  input  logic                is_write_i,
  input  logic                is_unsigned_i,
  input  logic [1:0]          op_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [XLEN-1:0]     in_i,
  output logic [XLEN-1:0]     out_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                fault_o,
  output logic [1:0]          fault_cause_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [XLEN-1:0]     bus_wdata_o,
  output logic [XLEN/8-1:0]   bus_wstrb_o,
  input  logic                bus_ack_i,
  input  logic                bus_err_i,
  input  logic [XLEN-1:0]     bus_rdata_i
);

  localparam int NB    = XLEN / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE      = MAU_IDLE;
  localparam logic [1:0] ST_REQ       = MAU_REQ;
  localparam logic [1:0] ST_WAIT_DROP = MAU_WAIT_DROP;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic [1:0]        cause_q, cause_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]     wstrb_q, wstrb_d;
  logic [1:0]        rd_op_q, rd_op_d;
  logic [OFFW-1:0]   rd_off_q, rd_off_d;
  logic              rd_uns_q, rd_uns_d;

  logic [OFFW-1:0]   off;
  logic              size_invalid;
  logic              misaligned;
  logic              timeout_hit;
  logic [NB-1:0]     lane_wstrb;
  logic [XLEN-1:0]   lane_wdata;
  logic [XLEN-1:0]   rd_ext;

  assign off          = addr_i[OFFW-1:0];
  assign size_invalid = (op_i == SIZE_DOUBLE) && (XLEN == 32);
  assign misaligned   = (off & OFFW'(size_bytes(op_i) - 4'd1)) != '0;
  assign timeout_hit  = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Read side works from the offset/size captured at issue, not the live inputs.
  mem_lane_align #(.XLEN(XLEN)) u_lane (
    .wr_op_i       (op_i),
    .wr_off_i      (off),
    .wr_data_i     (in_i),
    .wstrb_o       (lane_wstrb),
    .wdata_o       (lane_wdata),
    .rd_op_i       (rd_op_q),
    .rd_off_i      (rd_off_q),
    .rd_unsigned_i (rd_uns_q),
    .rd_data_i     (bus_rdata_i),
    .rd_ext_o      (rd_ext)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fault_d  = fault_q;
    cause_d  = cause_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rd_op_d  = rd_op_q;
    rd_off_d = rd_off_q;
    rd_uns_d = rd_uns_q;
    case (state_q)
      ST_IDLE: begin
        if (available_i) begin
          if (size_invalid) begin
            state_d = ST_WAIT_DROP;
            fault_d = 1'b1;
            cause_d = FAULT_SIZE;
          end else if (misaligned) begin
            state_d = ST_WAIT_DROP;
            fault_d = 1'b1;
            cause_d = FAULT_MISALIGN;
          end else begin
            state_d  = ST_REQ;
            cnt_d    = '0;
            busy_d   = 1'b1;
            req_d    = 1'b1;
            we_d     = is_write_i;
            addr_d   = {addr_i[ADDR_W-1:OFFW], OFFW'(0)};
            wdata_d  = lane_wdata;
            wstrb_d  = lane_wstrb;
            rd_op_d  = op_i;
            rd_off_d = off;
            rd_uns_d = is_unsigned_i;
          end
        end
      end
      ST_REQ: begin
        if (bus_ack_i) begin
          state_d = ST_WAIT_DROP;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          if (bus_err_i) begin
            fault_d = 1'b1;
            cause_d = FAULT_BUS;
          end else begin
            done_d = 1'b1;
            if (!we_q) out_d = rd_ext;
          end
        end else if (timeout_hit) begin
          state_d = ST_WAIT_DROP;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          fault_d = 1'b1;
          cause_d = FAULT_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // A new access may only start once the requester has dropped available.
      ST_WAIT_DROP: begin
        if (!available_i) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      cause_q  <= 2'b00;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rd_op_q  <= 2'b00;
      rd_off_q <= '0;
      rd_uns_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      cause_q  <= cause_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rd_op_q  <= rd_op_d;
      rd_off_q <= rd_off_d;
      rd_uns_q <= rd_uns_d;
    end
  end

  assign out_o         = out_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign fault_o       = fault_q;
  assign fault_cause_o = cause_q;
  assign bus_req_o     = req_q;
  assign bus_we_o      = we_q;
  assign bus_addr_o    = addr_q;
  assign bus_wdata_o   = wdata_q;
  assign bus_wstrb_o   = wstrb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a 32-bit instance (TIMEOUT=4) and a
// 64-bit instance (timeout disabled) share one driver and one bus responder.
module tb_mem_access_unit;

  typedef struct {
    logic        isFault;
    logic [1:0]  cause;
    logic [63:0] outVal;
  } expT;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel64;
  logic        availDrv, writeDrv, unsDrv, strayAck;
  logic [1:0]  opDrv;
  logic [31:0] addrDrv;
  logic [63:0] inDrv, rdataDrv;
  logic        ackResp, errResp;
  int          respMode, respDelay, waitCnt;
  int          reqCycles, busyCycles;
  int          checkCount, errorCount;

  expT         sbQ[$];
  expT         ev;
  logic [63:0] lastOut [2];
  logic        faultPrev;

  logic        avail32, ack32, avail64, ack64;
  logic [31:0] out32, baddr32, wdata32;
  logic [3:0]  wstrb32;
  logic        busy32, done32, fault32, req32, we32;
  logic [1:0]  cause32;
  logic [63:0] out64, wdata64;
  logic [31:0] baddr64;
  logic [7:0]  wstrb64;
  logic        busy64, done64, fault64, req64, we64;
  logic [1:0]  cause64;

  logic [63:0] outObs, wdataObs;
  logic [31:0] addrObs;
  logic [7:0]  strbObs;
  logic        busyObs, doneObs, faultObs, reqObs, weObs;
  logic [1:0]  causeObs;

  always #5 clk = ~clk;

  assign avail32  = availDrv & ~sel64;
  assign avail64  = availDrv & sel64;
  assign ack32    = (ackResp | strayAck) & ~sel64;
  assign ack64    = (ackResp | strayAck) & sel64;
  assign outObs   = sel64 ? out64   : {32'b0, out32};
  assign wdataObs = sel64 ? wdata64 : {32'b0, wdata32};
  assign addrObs  = sel64 ? baddr64 : baddr32;
  assign strbObs  = sel64 ? wstrb64 : {4'b0, wstrb32};
  assign busyObs  = sel64 ? busy64  : busy32;
  assign doneObs  = sel64 ? done64  : done32;
  assign faultObs = sel64 ? fault64 : fault32;
  assign reqObs   = sel64 ? req64   : req32;
  assign weObs    = sel64 ? we64    : we32;
  assign causeObs = sel64 ? cause64 : cause32;

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .reset(reset), .available_i(avail32), .is_write_i(writeDrv),
    .is_unsigned_i(unsDrv), .op_i(opDrv), .addr_i(addrDrv), .in_i(inDrv[31:0]),
    .out_o(out32), .busy_o(busy32), .done_o(done32), .fault_o(fault32),
    .fault_cause_o(cause32), .bus_req_o(req32), .bus_we_o(we32),
    .bus_addr_o(baddr32), .bus_wdata_o(wdata32), .bus_wstrb_o(wstrb32),
    .bus_ack_i(ack32), .bus_err_i(errResp), .bus_rdata_i(rdataDrv[31:0])
  );

  mem_access_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(0)) dut64 (
    .clk(clk), .reset(reset), .available_i(avail64), .is_write_i(writeDrv),
    .is_unsigned_i(unsDrv), .op_i(opDrv), .addr_i(addrDrv), .in_i(inDrv),
    .out_o(out64), .busy_o(busy64), .done_o(done64), .fault_o(fault64),
    .fault_cause_o(cause64), .bus_req_o(req64), .bus_we_o(we64),
    .bus_addr_o(baddr64), .bus_wdata_o(wdata64), .bus_wstrb_o(wstrb64),
    .bus_ack_i(ack64), .bus_err_i(errResp), .bus_rdata_i(rdataDrv)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] modelLoad(input logic [63:0] rd, input int xl, input logic [1:0] sz,
                                            input int off, input logic uns);
    logic [63:0] sh, r;
    sh = rd >> (8 * off);
    case (sz)
      2'd0:    r = uns ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    r = uns ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    r = uns ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: r = sh;
    endcase
    if (xl == 32) r = r & 64'hFFFF_FFFF;
    return r;
  endfunction

  // Bus responder: acks after respDelay wait cycles; mode 1 flags an error, mode 2 never answers.
  always @(negedge clk) begin
    ackResp = 1'b0;
    errResp = 1'b0;
    if (reqObs && respMode != 2) begin
      if (waitCnt == respDelay) begin
        ackResp = 1'b1;
        errResp = (respMode == 1);
        waitCnt = 0;
      end else begin
        waitCnt++;
      end
    end else if (!reqObs) begin
      waitCnt = 0;
    end
    if (reqObs)  reqCycles++;
    if (busyObs) busyCycles++;
  end

  // Completion monitor: every done pulse or fault rise pops one expected result.
  always @(negedge clk) begin
    if (reset) begin
      faultPrev = 1'b0;
    end else begin
      if (doneObs || (faultObs && !faultPrev)) begin
        if (sbQ.size() == 0) begin
          checkOutput("sbUnderflow", 64'(sbQ.size()), 64'd1);
        end else begin
          ev = sbQ.pop_front();
          checkOutput("evFault", 64'(faultObs), 64'(ev.isFault));
          checkOutput("evDone", 64'(doneObs), 64'(!ev.isFault));
          if (ev.isFault) checkOutput("evCause", 64'(causeObs), 64'(ev.cause));
          checkOutput("evOut", outObs, ev.outVal);
        end
      end
      faultPrev = faultObs;
    end
  end

  task automatic applyStimulus(input string tag, input logic wr, input logic uns, input logic [1:0] sz,
                               input logic [31:0] a, input logic [63:0] d, input logic [63:0] rd,
                               input int mode, input int delay, input bit dropEarly);
    int xl, off, nBytes, waitN, expCycles;
    expT ex;
    bit legal;
    logic [7:0] m;
    xl = sel64 ? 64 : 32;
    off = int'(a) & (xl / 8 - 1);
    nBytes = 1 << sz;
    legal = 1'b0;
    ex.outVal = lastOut[sel64];
    ex.isFault = 1'b1;
    ex.cause = 2'd0;
    if (sz == 2'd3 && xl == 32) ex.cause = 2'd0;
    else if (off % nBytes != 0) ex.cause = 2'd1;
    else begin
      legal = 1'b1;
      if (mode == 1) ex.cause = 2'd2;
      else if (mode == 2) ex.cause = 2'd3;
      else begin
        ex.isFault = 1'b0;
        if (!wr) ex.outVal = modelLoad(rd, xl, sz, off, uns);
      end
    end
    lastOut[sel64] = ex.outVal;
    sbQ.push_back(ex);
    writeDrv = wr; unsDrv = uns; opDrv = sz; addrDrv = a; inDrv = d; rdataDrv = rd;
    respMode = mode; respDelay = delay; reqCycles = 0; busyCycles = 0;
    availDrv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, ".req"}, 64'(reqObs), 64'(legal));
    if (legal) begin
      case (sz)
        2'd0: m = 8'h01;
        2'd1: m = 8'h03;
        2'd2: m = 8'h0F;
        default: m = 8'hFF;
      endcase
      checkOutput({tag, ".we"}, 64'(weObs), 64'(wr));
      checkOutput({tag, ".addr"}, 64'(addrObs), 64'(a & ~32'(xl / 8 - 1)));
      checkOutput({tag, ".strb"}, 64'(strbObs), 64'(8'(m << off)));
      if (wr) checkOutput({tag, ".wdata"}, wdataObs, d << (8 * off));
    end
    waitN = 0;
    while (!(doneObs || faultObs) && waitN < 40) begin
      if (dropEarly) availDrv = 1'b0;
      @(negedge clk);
      waitN++;
    end
    checkOutput({tag, ".complete"}, 64'(doneObs || faultObs), 64'd1);
    checkOutput({tag, ".busyOff"}, 64'(busyObs), 64'd0);
    checkOutput({tag, ".reqOff"}, 64'(reqObs), 64'd0);
    if (legal) begin
      expCycles = (mode == 2) ? 4 : delay + 1;
      checkOutput({tag, ".reqCycles"}, 64'(reqCycles), 64'(expCycles));
      checkOutput({tag, ".busyCycles"}, 64'(busyCycles), 64'(expCycles));
    end
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, 64'(doneObs), 64'd0);
    if (ex.isFault && !dropEarly) checkOutput({tag, ".faultHeld"}, 64'(faultObs), 64'd1);
    availDrv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, ".faultClr"}, 64'(faultObs), 64'd0);
  endtask

  initial begin
    checkCount = 0; errorCount = 0;
    reset = 1'b1; sel64 = 1'b0; availDrv = 1'b0; writeDrv = 1'b0; unsDrv = 1'b0;
    strayAck = 1'b0; opDrv = 2'd0; addrDrv = '0; inDrv = '0; rdataDrv = '0;
    respMode = 0; respDelay = 0; waitCnt = 0; reqCycles = 0; busyCycles = 0;
    lastOut[0] = '0; lastOut[1] = '0; faultPrev = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst.out", outObs, 64'd0);
    checkOutput("rst.busy", 64'(busyObs), 64'd0);
    checkOutput("rst.done", 64'(doneObs), 64'd0);
    checkOutput("rst.fault", 64'(faultObs), 64'd0);
    checkOutput("rst.cause", 64'(causeObs), 64'd0);
    checkOutput("rst.req", 64'(reqObs), 64'd0);
    checkOutput("rst.addr", 64'(addrObs), 64'd0);
    checkOutput("rst.strb", 64'(strbObs), 64'd0);
    checkOutput("rst.req64", 64'(req64), 64'd0);
    checkOutput("rst.out64", out64, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus("ldb",   1'b0, 1'b0, 2'd0, 32'h1003, 64'd0, 64'h80FF_FFFF, 0, 0, 1'b0);
    applyStimulus("sth",   1'b1, 1'b0, 2'd1, 32'h2002, 64'h0000_ABCD, 64'd0, 0, 0, 1'b0);
    applyStimulus("badSz", 1'b0, 1'b0, 2'd3, 32'h0000, 64'd0, 64'd0, 0, 0, 1'b0);
    applyStimulus("misW",  1'b0, 1'b0, 2'd2, 32'h0003, 64'd0, 64'd0, 0, 0, 1'b0);
    applyStimulus("both",  1'b0, 1'b0, 2'd3, 32'h0003, 64'd0, 64'd0, 0, 0, 1'b0);
    applyStimulus("misH",  1'b0, 1'b0, 2'd1, 32'h0101, 64'd0, 64'd0, 0, 0, 1'b0);
    applyStimulus("ldhu",  1'b0, 1'b1, 2'd1, 32'h0002, 64'd0, 64'hBEEF_1234, 0, 2, 1'b1);
    applyStimulus("ldhs",  1'b0, 1'b0, 2'd1, 32'h0000, 64'd0, 64'h0000_8765, 0, 1, 1'b0);
    applyStimulus("tmo",   1'b0, 1'b0, 2'd2, 32'h0040, 64'd0, 64'd0, 2, 0, 1'b0);
    applyStimulus("berr",  1'b1, 1'b0, 2'd2, 32'h0044, 64'h1122_3344, 64'd0, 1, 0, 1'b0);
    applyStimulus("ldbu",  1'b0, 1'b1, 2'd0, 32'h1001, 64'd0, 64'h0000_C300, 0, 0, 1'b0);
    applyStimulus("stb",   1'b1, 1'b0, 2'd0, 32'h0007, 64'h0000_005A, 64'd0, 0, 0, 1'b0);

    strayAck = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("stray.done", 64'(doneObs), 64'd0);
    checkOutput("stray.busy", 64'(busyObs), 64'd0);
    checkOutput("stray.fault", 64'(faultObs), 64'd0);
    strayAck = 1'b0;
    @(negedge clk);

    writeDrv = 1'b0; unsDrv = 1'b0; opDrv = 2'd2; addrDrv = 32'h10; respMode = 2;
    availDrv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstMid.reqBefore", 64'(reqObs), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstMid.req", 64'(reqObs), 64'd0);
    checkOutput("rstMid.busy", 64'(busyObs), 64'd0);
    checkOutput("rstMid.fault", 64'(faultObs), 64'd0);
    sbQ.delete();
    lastOut[0] = '0;
    lastOut[1] = '0;
    reset = 1'b0;
    applyStimulus("fresh", 1'b0, 1'b0, 2'd2, 32'h0010, 64'd0, 64'h1234_5678, 0, 0, 1'b0);

    sel64 = 1'b1;
    @(negedge clk);
    applyStimulus("ldd",   1'b0, 1'b0, 2'd3, 32'h0008, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 0, 1'b0);
    applyStimulus("ldw64", 1'b0, 1'b0, 2'd2, 32'h0004, 64'd0, 64'hFEDC_BA98_7654_3210, 0, 1, 1'b0);
    applyStimulus("ldwu",  1'b0, 1'b1, 2'd2, 32'h0004, 64'd0, 64'hFEDC_BA98_7654_3210, 0, 0, 1'b0);
    applyStimulus("stb64", 1'b1, 1'b0, 2'd0, 32'h0005, 64'h0000_00AB, 64'd0, 0, 0, 1'b0);
    applyStimulus("misD",  1'b0, 1'b0, 2'd3, 32'h0004, 64'd0, 64'd0, 0, 0, 1'b0);
    applyStimulus("lddu",  1'b0, 1'b1, 2'd3, 32'h0010, 64'd0, 64'hF000_0000_0000_0001, 0, 0, 1'b0);
    applyStimulus("berr64",1'b0, 1'b0, 2'd1, 32'h0006, 64'd0, 64'hFFFF_0000_0000_0000, 1, 0, 1'b0);

    checkOutput("sbEmpty", 64'(sbQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store unit between the execute stage and a generic single-outstanding memory bus.
- Accepts one sized access per `available` assertion and checks size/alignment before issuing.
- Drives a req/ack bus with byte strobes, aligns write data to byte lanes, and extracts/extends read data.
- Reports completion, or a fault with a cause code (invalid size, misaligned, bus error, timeout).

Parameters:
- XLEN, 32, data path width; 32 or 64 only.
- ADDR_W, 32, address width.
- TIMEOUT, 256, max cycles waiting for bus response; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- available  in  1  operation request, level; held until done or fault seen
- is_write  in  1  1=store, 0=load
- is_unsigned  in  1  loads: zero-extend (1) or sign-extend (0)
- op  in  2  size: 00 byte, 01 half, 10 word, 11 double (legal only when XLEN=64)
- addr  in  ADDR_W  byte address
- in  in  XLEN  store data, right-justified
- out  out  XLEN  load result, extended
- busy  out  1  access in flight
- done  out  1  one-cycle completion pulse
- fault  out  1  fault flag
- fault_cause  out  2  00 invalid size, 01 misaligned, 10 bus error, 11 timeout
- bus_req  out  1  bus request
- bus_we  out  1  bus write enable
- bus_addr  out  ADDR_W  address with low log2(XLEN/8) bits cleared
- bus_wdata  out  XLEN  lane-aligned store data
- bus_wstrb  out  XLEN/8  byte enables
- bus_ack  in  1  response valid
- bus_err  in  1  response is an error; valid only with bus_ack
- bus_rdata  in  XLEN  read data, valid with bus_ack

Behaviour:
- Reset: all outputs 0, fault_cause 00, state IDLE, timeout counter 0. Reset mid-access abandons it and bus_req drops the next cycle; the bus must tolerate abandoned requests.
- FSM states: IDLE, REQ, WAIT_DROP.
- IDLE, available=1, size invalid: go to WAIT_DROP. Next cycle fault=1, cause=00. No bus request is issued.
- IDLE, available=1, misaligned: go to WAIT_DROP. Next cycle fault=1, cause=01. No bus request is issued.
  - Misaligned means: half with addr[0]; word with addr[1:0]≠0; double with addr[2:0]≠0.
  - When both faults apply, invalid size wins.
- IDLE, available=1, legal access:
  - Next cycle: busy=1, bus_req=1; bus_we, bus_addr, bus_wdata, bus_wstrb registered from the inputs.
  - Go to REQ and clear the counter.
- REQ: bus_req and the bus fields are held stable until bus_ack is sampled.
  - bus_ack=1, bus_err=0: go to WAIT_DROP. Next cycle bus_req=0, busy=0, done=1 for one cycle. On loads, out is updated; on stores, out is held.
  - bus_ack=1, bus_err=1: same, but done=0, fault=1, cause=10, and out is unchanged.
  - No ack and counter=TIMEOUT-1 (TIMEOUT>0): go to WAIT_DROP; bus_req=0, busy=0, fault=1, cause=11.
  - Otherwise increment the counter.
- WAIT_DROP: fault and fault_cause are held. When available=0 is sampled, go to IDLE and clear fault next cycle. An access therefore needs `available` to fall before the next one can start.
- Lane rules: off = addr[log2(XLEN/8)-1:0].
  - bus_wstrb = ((1<<2^op)-1) << off.
  - bus_wdata = in << (8*off); unselected lanes don't-care, driven 0.
  - out = bus_rdata >> (8*off), truncated to size, then sign/zero-extended to XLEN.
  - Double loads ignore is_unsigned.
- Latency: a load with zero-wait-state ack (ack in the first REQ cycle) gives done 2 cycles after available is first sampled.
- available dropping during REQ does not abort: the access completes, then the FSM returns to IDLE directly from WAIT_DROP.
- bus_ack outside REQ is ignored.

Decomposition:
- Package mem_pkg:
  - mem_size_e (BYTE, HALF, WORD, DOUBLE)
  - mem_fault_e (four causes)
  - mau_state_e (IDLE, REQ, WAIT_DROP)
  - function size_bytes(op)
- Sub-module mem_lane_align: purely combinational; produces wstrb/wdata shift and read extract/extend, parametrised by XLEN. The FSM, counter and registers stay in mem_access_unit.

Test Plan:
- XLEN=32, load byte addr=0x1003, is_unsigned=0, bus_rdata=0x80FFFFFF, ack after 1 cycle -> bus_addr=0x1000, bus_wstrb=0b1000, out=0xFFFFFF80, done one pulse, busy high 1 cycle.
- XLEN=32, store half addr=0x2002, in=0x0000ABCD -> bus_we=1, bus_wstrb=0b1100, bus_wdata[31:16]=0xABCD; out unchanged.
- XLEN=32, op=11, then op=10 addr=0x3 -> fault, cause=00 then cause=01; bus_req never asserted; fault held until available drops.
- XLEN=64, load double addr=0x8, bus_rdata=0x0123456789ABCDEF -> out=0x0123456789ABCDEF, bus_wstrb=0xFF.
- TIMEOUT=4, bus never acks -> bus_req high exactly 4 cycles, then busy=0, fault=1, cause=11; bus_ack with bus_err -> cause=10, done=0.
- Reset asserted during REQ -> next cycle bus_req=0, busy=0, fault=0; holding available high after reset starts a fresh access.
